// File: rtl/lfo_param_ctrl_pkg.sv
// Shared types and constants for the LFO parameter controller and LFOgen.
package lfo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_ZC = 2'd1,
    RAMP    = 2'd2
  } lfo_state_t;

  localparam int SET_W    = 4;
  localparam int SAMPLE_W = 16;

  // Named frequency codes understood by LFOgen.
  localparam logic [SET_W-1:0] FREQ_1HZ = 4'b0011;
  localparam logic [SET_W-1:0] FREQ_4HZ = 4'b1101;

  // 6 MHz system clock / 48 kHz sample rate.
  localparam int CLK_DIV_DEF    = 125;
  // About 1 ms between scale steps.
  localparam int RAMP_TICKS_DEF = 48;
  // About 100 ms before a frequency change is forced.
  localparam int ZC_TIMEOUT_DEF = 4800;

endpackage

// File: rtl/lfo_param_ctrl_if.sv
// Request channel from the control register bank: one {freq, scale} pair per transfer.
interface lfo_param_ctrl_if;

  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [lfo_pkg::SET_W-1:0] cfg_freq;
  logic [lfo_pkg::SET_W-1:0] cfg_scale;

  // Register bank side.
  modport master (
    output cfg_valid,
    output cfg_freq,
    output cfg_scale,
    input  cfg_ready
  );

  // Controller side.
  modport slave (
    input  cfg_valid,
    input  cfg_freq,
    input  cfg_scale,
    output cfg_ready
  );

endinterface

// File: rtl/lfo_param_ctrl_tick_gen.sv
// Sample-rate strobe generator: one-cycle pulse every CLK_DIV system clocks.
module tick_gen #(
  parameter int CLK_DIV = lfo_pkg::CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Free-running divider counting 0..CLK_DIV-1.
  // NOTE: sequential state is only ever updated with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/lfo_param_ctrl.sv
// Click-free sequencing of freq/scale changes into LFOgen: frequency switches at a
// waveform zero crossing (or on timeout), scale ramps one code per RAMP_TICKS ticks.
module lfo_param_ctrl
  import lfo_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int RAMP_TICKS = RAMP_TICKS_DEF,
  parameter int ZC_TIMEOUT = ZC_TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  lfo_param_ctrl_if.slave            cfg,
  input  logic signed [SAMPLE_W-1:0] wave_in,
  output logic                       tick48k,
  output logic [SET_W-1:0]           freqSetting,
  output logic [SET_W-1:0]           scaleFactor,
  output logic                       busy
);

  localparam int ZC_W   = (ZC_TIMEOUT > 1) ? $clog2(ZC_TIMEOUT) : 1;
  localparam int RAMP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam logic [ZC_W-1:0]   ZC_LAST   = ZC_W'(ZC_TIMEOUT - 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_TICKS - 1);

  lfo_state_t        r_state,     w_state_nxt;
  logic [SET_W-1:0]  r_freq,      w_freq_nxt;
  logic [SET_W-1:0]  r_scale,     w_scale_nxt;
  logic [SET_W-1:0]  r_tgt_freq,  w_tgt_freq_nxt;
  logic [SET_W-1:0]  r_tgt_scale, w_tgt_scale_nxt;
  logic              r_prev_sign, w_prev_sign_nxt;
  logic [ZC_W-1:0]   r_zc_cnt,    w_zc_cnt_nxt;
  logic [RAMP_W-1:0] r_ramp_cnt,  w_ramp_cnt_nxt;
  logic              w_tick;
  logic              w_crossing;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Crossing compares against the sign seen on the previous tick, before it is refreshed.
  assign w_crossing = (wave_in == '0) || (wave_in[SAMPLE_W-1] != r_prev_sign);

  // State and datapath registers; reset clears every bit of in-flight update state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_freq      <= '0;
      r_scale     <= '0;
      r_tgt_freq  <= '0;
      r_tgt_scale <= '0;
      r_prev_sign <= 1'b0;
      r_zc_cnt    <= '0;
      r_ramp_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_freq      <= w_freq_nxt;
      r_scale     <= w_scale_nxt;
      r_tgt_freq  <= w_tgt_freq_nxt;
      r_tgt_scale <= w_tgt_scale_nxt;
      r_prev_sign <= w_prev_sign_nxt;
      r_zc_cnt    <= w_zc_cnt_nxt;
      r_ramp_cnt  <= w_ramp_cnt_nxt;
    end
  end

  // Next-state and next-datapath logic; WAIT_ZC and RAMP only act on tick cycles.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no latch can be inferred.
    w_state_nxt     = r_state;
    w_freq_nxt      = r_freq;
    w_scale_nxt     = r_scale;
    w_tgt_freq_nxt  = r_tgt_freq;
    w_tgt_scale_nxt = r_tgt_scale;
    w_prev_sign_nxt = r_prev_sign;
    w_zc_cnt_nxt    = r_zc_cnt;
    w_ramp_cnt_nxt  = r_ramp_cnt;

    if (w_tick) begin
      w_prev_sign_nxt = wave_in[SAMPLE_W-1];
    end

    case (r_state)
      IDLE: begin
        if (cfg.cfg_valid) begin
          w_tgt_freq_nxt  = cfg.cfg_freq;
          w_tgt_scale_nxt = cfg.cfg_scale;
          if (cfg.cfg_freq != r_freq) begin
            w_state_nxt  = WAIT_ZC;
            w_zc_cnt_nxt = '0;
          end else if (cfg.cfg_scale != r_scale) begin
            w_state_nxt    = RAMP;
            w_ramp_cnt_nxt = '0;
          end
        end
      end

      WAIT_ZC: begin
        if (w_tick) begin
          if (w_crossing || (r_zc_cnt == ZC_LAST)) begin
            w_freq_nxt     = r_tgt_freq;
            w_ramp_cnt_nxt = '0;
            w_state_nxt    = RAMP;
          end else begin
            w_zc_cnt_nxt = r_zc_cnt + ZC_W'(1);
          end
        end
      end

      RAMP: begin
        if (w_tick) begin
          if (r_scale == r_tgt_scale) begin
            w_state_nxt = IDLE;
          end else if (r_ramp_cnt == RAMP_LAST) begin
            // Single step toward the target; the equality test above prevents overshoot or wrap.
            w_scale_nxt    = (r_tgt_scale > r_scale) ? r_scale + SET_W'(1)
                                                     : r_scale - SET_W'(1);
            w_ramp_cnt_nxt = '0;
          end else begin
            w_ramp_cnt_nxt = r_ramp_cnt + RAMP_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign cfg.cfg_ready = (r_state == IDLE);
  assign busy          = (r_state != IDLE);
  assign tick48k       = w_tick;
  assign freqSetting   = r_freq;
  assign scaleFactor   = r_scale;

endmodule
